moore_pattern_detector: RTL and testbench

//  Parametrised Moore serial-pattern detector, next generation of the fixed "x000" detector.

---
 rtl/moore_pattern_detector_pkg.sv | 14 +
 rtl/moore_pattern_detector_sat_counter.sv | 29 ++
 rtl/moore_pattern_detector.sv | 66 ++++++
 tb/tb_moore_pattern_detector.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/moore_pattern_detector_pkg.sv
// moore_pattern_detector_pkg: shared constants and the masked-compare helper
package moore_pattern_detector_pkg;

    localparam int MAX_PAT_W = 16;

    function automatic logic masked_eq(
        input logic [MAX_PAT_W-1:0] hist,
        input logic [MAX_PAT_W-1:0] pattern,
        input logic [MAX_PAT_W-1:0] mask
    );
        return ((hist ^ pattern) & mask) == '0;
    endfunction

endpackage

// File: rtl/moore_pattern_detector_sat_counter.sv
// sat_counter: saturating up-counter with synchronous clear taking priority
module sat_counter #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] count,
    output logic             sat
);

    logic [CNT_W-1:0] count_q, count_d;

    assign sat   = &count_q;
    assign count = count_q;

    // next count: clear wins, increment stops at all-ones
    always_comb begin
        count_d = clr ? '0 : (inc && !sat) ? count_q + 1'b1 : count_q;
    end

    // count register, async active-low reset
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) count_q <= '0;
        else        count_q <= count_d;
    end

endmodule

// File: rtl/moore_pattern_detector.sv
// moore_pattern_detector: Moore serial-pattern detector with enable, overlap mode and hit counter
module moore_pattern_detector
    import moore_pattern_detector_pkg::*;
#(
    parameter int             PAT_W   = 4,
    parameter logic [PAT_W-1:0] PATTERN = 4'b1000,
    parameter logic [PAT_W-1:0] MASK    = 4'b0111,
    parameter bit             OVERLAP = 1'b1,
    parameter int             CNT_W   = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             x,
    input  logic             clr_cnt,
    output logic             y,
    output logic [CNT_W-1:0] hit_count,
    output logic             cnt_sat
);

    localparam int FILL_W = $clog2(PAT_W + 1);
    localparam logic [FILL_W-1:0] FULL = FILL_W'(PAT_W);

    if (PAT_W < 2 || PAT_W > MAX_PAT_W || MASK == '0) begin : g_bad_cfg
        $error("moore_pattern_detector: illegal PAT_W/MASK configuration");
    end

    logic [PAT_W-1:0]  hist_q, hist_d, hist_n;
    logic [FILL_W-1:0] fill_q, fill_d, fill_n;
    logic              match_q, match_d, hit;

    // candidate history/fill for an accepted bit, match test, and hold when en is low
    always_comb begin
        hist_n  = {hist_q[PAT_W-2:0], x};
        fill_n  = (fill_q == FULL) ? fill_q : fill_q + 1'b1;
        hit     = (fill_n == FULL) && masked_eq(MAX_PAT_W'(hist_n), MAX_PAT_W'(PATTERN), MAX_PAT_W'(MASK));
        hist_d  = en ? hist_n : hist_q;
        fill_d  = !en ? fill_q : (hit && !OVERLAP) ? '0 : fill_n;
        match_d = en ? hit : match_q;
    end

    // state registers, async active-low reset discards any partial history
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hist_q  <= '0;
            fill_q  <= '0;
            match_q <= 1'b0;
        end else begin
            hist_q  <= hist_d;
            fill_q  <= fill_d;
            match_q <= match_d;
        end
    end

    assign y = match_q;

    sat_counter #(.CNT_W(CNT_W)) u_cnt (
        .clk   (clk),
        .reset (reset),
        .clr   (clr_cnt),
        .inc   (en && hit),
        .count (hit_count),
        .sat   (cnt_sat)
    );

endmodule

// File: tb/tb_moore_pattern_detector.sv
// tb_moore_pattern_detector: three detector configurations against a behavioural model
module tb_moore_pattern_detector;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic en = 1'b0;
    logic x = 1'b0;
    logic clr_cnt = 1'b0;

    logic       y0, y1, y2, s0, s1, s2;
    logic [7:0] hc0, hc1;
    logic [1:0] hc2;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    moore_pattern_detector u_ovl (
        .clk(clk), .reset(reset), .en(en), .x(x), .clr_cnt(clr_cnt),
        .y(y0), .hit_count(hc0), .cnt_sat(s0)
    );

    moore_pattern_detector #(.OVERLAP(1'b0)) u_rst (
        .clk(clk), .reset(reset), .en(en), .x(x), .clr_cnt(clr_cnt),
        .y(y1), .hit_count(hc1), .cnt_sat(s1)
    );

    moore_pattern_detector #(.CNT_W(2)) u_c2 (
        .clk(clk), .reset(reset), .en(en), .x(x), .clr_cnt(clr_cnt),
        .y(y2), .hit_count(hc2), .cnt_sat(s2)
    );

    // model: "x000" means at least 4 bits since the last restart and the newest three are 0
    localparam int unsigned PAT = 8;
    localparam int unsigned MSK = 7;

    int unsigned since[3];
    int unsigned recent[3];
    int unsigned cnt[3];
    bit          ym[3];

    function automatic int unsigned cmax(input int k);
        return (k == 2) ? 3 : 255;
    endfunction

    function automatic bit overlap(input int k);
        return k != 1;
    endfunction

    task automatic check(input string tag, input int unsigned obs, input int unsigned exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 3; k++) begin
            since[k] = 0; recent[k] = 0; cnt[k] = 0; ym[k] = 0;
        end
    endtask

    task automatic model_edge(input bit xb, input bit eb, input bit cb);
        for (int k = 0; k < 3; k++) begin
            bit hit = 0;
            if (eb) begin
                recent[k] = (recent[k] * 2 + xb) % 16;
                since[k]  = since[k] + 1;
                hit       = since[k] >= 4 && ((recent[k] ^ PAT) & MSK) == 0;
                ym[k]     = hit;
                if (hit && !overlap(k)) since[k] = 0;
            end
            if (cb) cnt[k] = 0;
            else if (hit && cnt[k] < cmax(k)) cnt[k]++;
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".y0"}, y0, ym[0]);
        check({tag, ".cnt0"}, hc0, cnt[0]);
        check({tag, ".sat0"}, s0, cnt[0] == cmax(0));
        check({tag, ".y1"}, y1, ym[1]);
        check({tag, ".cnt1"}, hc1, cnt[1]);
        check({tag, ".sat1"}, s1, cnt[1] == cmax(1));
        check({tag, ".y2"}, y2, ym[2]);
        check({tag, ".cnt2"}, hc2, cnt[2]);
        check({tag, ".sat2"}, s2, cnt[2] == cmax(2));
    endtask

    task automatic step(input bit xb, input bit eb, input bit cb, input string tag);
        @(negedge clk);
        x = xb; en = eb; clr_cnt = cb;
        @(posedge clk);
        model_edge(xb, eb, cb);
        #1;
        check_all(tag);
    endtask

    task automatic pulse_reset(input string tag);
        reset = 1'b0;
        #1;
        model_reset();
        check_all(tag);
        #1 reset = 1'b1;
    endtask

    task automatic send(input bit [7:0] bits, input int n, input string tag);
        for (int i = n - 1; i >= 0; i--) step(bits[i], 1'b1, 1'b0, tag);
    endtask

    initial begin
        model_reset();
        #1;
        check_all("reset");
        #2 reset = 1'b1;

        send(8'b1000, 4, "t1");
        check("t1.y_hi", y0, 1);
        check("t1.cnt", hc0, 1);
        step(1'b1, 1'b1, 1'b0, "t1b");
        check("t1.y_lo", y0, 0);

        pulse_reset("t2r");
        send(8'b100000, 6, "t2");
        check("t2.cnt_ovl", hc0, 3);
        check("t3.cnt_restart", hc1, 1);
        send(8'b00, 2, "t3");
        check("t3.y_edge8", y1, 1);
        check("t3.cnt_edge8", hc1, 2);

        pulse_reset("t4r");
        send(8'b1000, 4, "t4");
        for (int i = 0; i < 3; i++) step(1'($urandom), 1'b0, 1'b0, "t4hold");
        check("t4.y_held", y0, 1);
        check("t4.cnt_held", hc0, 1);
        step(1'b1, 1'b1, 1'b0, "t4c");
        check("t4.y_drop", y0, 0);

        pulse_reset("t5r");
        for (int i = 0; i < 5; i++) send(8'b1000, 4, "t5");
        check("t5.cnt_sat_val", hc2, 3);
        check("t5.sat", s2, 1);
        send(8'b100, 3, "t5p");
        step(1'b0, 1'b1, 1'b1, "t5clr");
        check("t5.clr_cnt", hc2, 0);
        check("t5.clr_sat", s2, 0);

        pulse_reset("t6r");
        send(8'b100, 3, "t6");
        pulse_reset("t6mid");
        check("t6.y_zero", y0, 0);
        step(1'b0, 1'b1, 1'b0, "t6a");
        check("t6.no_match", y0, 0);
        send(8'b1000, 4, "t6b");
        check("t6.full_match", y0, 1);

        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(149) == 0) pulse_reset("rnd_rst");
            step($urandom_range(3) == 0, $urandom_range(4) != 0, $urandom_range(39) == 0, "rnd");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
